multicycle_control: RTL

//  Multicycle MIPS control FSM. It sequences fetch, decode, execute, memory and writeback over several clocks.
//  It drives the shared-ALU/shared-memory datapath and supports the opcode set R, ADDI, LUI, ORI, ANDI, LW, SW, BEQ, BNE, J, JAL.
//  It adds a ready handshake with memory, a memory watchdog and illegal-opcode reporting. Sits between IR opcode field and datapath muxes.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for the multicycle MIPS controller
interface multicycle_control_if #(
  parameter int ALU_OP_WIDTH = 3
);
  logic [5:0]              opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    pc_write;
  logic [1:0]              pc_src;
  logic                    ir_write;
  logic                    i_or_d;
  logic                    mem_read;
  logic                    mem_write;
  logic                    reg_write;
  logic [1:0]              reg_dst;
  logic [1:0]              mem_to_reg;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [3:0]              state;
  logic                    illegal_op;
  logic                    bus_error;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal_op, bus_error
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal_op, bus_error
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory handshake, watchdog and illegal-opcode pulse
module multicycle_control #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALU_WB = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam bit             WDOG_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_n;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wdog;
  logic             illegal_q, illegal_n;
  logic             bus_err;
  logic [2:0]       alu3;
  logic             expire;
  logic             waiting;

  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign expire  = WDOG_EN && (wdog == WDOG_LAST) && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      op_q      <= 6'd0;
      wdog      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_n;
      illegal_q <= illegal_n;
      if (state == S_DECODE) op_q <= bus.opcode;
      // Any state change (or an expiry that re-enters FETCH) restarts the wait count.
      if (state_n != state || bus_err) wdog <= '0;
      else if (waiting && !bus.mem_ready) wdog <= wdog + 1'b1;
    end
  end

  always_comb begin
    state_n        = state;
    illegal_n      = 1'b0;
    bus_err        = 1'b0;
    alu3           = 3'b000;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'd1;
        alu3          = 3'b100;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_n      = S_DECODE;
        end else if (expire) begin
          bus_err = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_DECODE: begin
        bus.alu_src_b = 2'd3;
        alu3          = 3'b100;
        case (bus.opcode)
          OP_R, OP_ADDI, OP_LUI, OP_ORI, OP_ANDI: state_n = S_EXEC;
          OP_LW, OP_SW:                           state_n = S_ADDR;
          OP_BEQ, OP_BNE:                         state_n = S_BRANCH;
          OP_J, OP_JAL:                           state_n = S_JUMP;
          default: begin
            state_n   = S_FETCH;
            illegal_n = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = (op_q == OP_R) ? 2'd0 : 2'd2;
        case (op_q)
          OP_R:    alu3 = 3'b111;
          OP_LUI:  alu3 = 3'b000;
          OP_ORI:  alu3 = 3'b001;
          OP_ANDI: alu3 = 3'b010;
          default: alu3 = 3'b100;
        endcase
        state_n = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (op_q == OP_R) ? 2'd1 : 2'd0;
        state_n       = S_FETCH;
      end
      S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
        alu3          = 3'b100;
        state_n       = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) state_n = S_MEM_WB;
        else if (expire) begin
          bus_err = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'd1;
        state_n        = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) state_n = S_FETCH;
        else if (expire) begin
          bus_err = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        alu3          = 3'b011;
        bus.pc_src    = 2'd1;
        bus.pc_write  = ((op_q == OP_BEQ) && bus.zero) || ((op_q == OP_BNE) && !bus.zero);
        state_n       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'd2;
        if (op_q == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'd2;
          bus.mem_to_reg = 2'd2;
        end
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  assign bus.alu_op     = ALU_OP_WIDTH'(alu3);
  assign bus.state      = state;
  assign bus.illegal_op = illegal_q;
  assign bus.bus_error  = bus_err;
endmodule
